// File: rtl/multi_clk_gen.sv
// multi_clk_gen
//   Multi-channel programmable divided-clock / tick generator. Each of NCH
//   channels counts i_clk cycles up to its active limit; at every wrap the
//   channel phase toggles and a one-cycle tick is produced. The limit of the
//   addressed channel is adjusted by saturating inc/dec commands into a
//   pending register that is copied into the active limit only at a wrap, so
//   a half-period in progress always completes with the limit it started with.
//   A sync pulse restarts every channel at phase 0 with its pending limit.
//
// Parameters
//   NCH      number of channels (1..16)
//   SW       width of i_sel, 2**SW >= NCH
//   CW       counter / limit width
//   LIM_MIN  lowest limit (>= 1)
//   LIM_MAX  highest limit (< 2**CW)
//   LIM_INIT limit loaded by reset
//
// Ports
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   i_sel      channel addressed by i_inc / i_dec / i_tog_en
//   i_inc      pulse: pending limit of selected channel +1 (saturating)
//   i_dec      pulse: pending limit of selected channel -1 (saturating)
//   i_tog_en   pulse: invert enable of selected channel
//   i_sync     pulse: restart all channels at phase 0
//   o_clk      divided clocks, gated by enable (flop outputs)
//   o_tick     one-cycle pulse per phase toggle, not gated (flop outputs)
//   o_en       per-channel enable (flop outputs)
//   o_lim_sel  pending limit of the selected channel, 0 if i_sel >= NCH
`timescale 1ns/1ps

module multi_clk_gen #(
  parameter int NCH      = 4,
  parameter int SW       = 2,
  parameter int CW       = 8,
  parameter int LIM_MIN  = 1,
  parameter int LIM_MAX  = 200,
  parameter int LIM_INIT = 1
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic [SW-1:0]  i_sel,
  input  logic           i_inc,
  input  logic           i_dec,
  input  logic           i_tog_en,
  input  logic           i_sync,
  output logic [NCH-1:0] o_clk,
  output logic [NCH-1:0] o_tick,
  output logic [NCH-1:0] o_en,
  output logic [CW-1:0]  o_lim_sel
);

  localparam logic [CW-1:0] LIM_MIN_C  = CW'(LIM_MIN);
  localparam logic [CW-1:0] LIM_MAX_C  = CW'(LIM_MAX);
  localparam logic [CW-1:0] LIM_INIT_C = CW'(LIM_INIT);
  localparam logic [CW-1:0] ONE_C      = CW'(1);

  // Saturating limit adjustment: never wraps past LIM_MAX / LIM_MIN.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    if (v < LIM_MAX_C) r = v + ONE_C;
    return r;
  endfunction

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    if (v > LIM_MIN_C) r = v - ONE_C;
    return r;
  endfunction

  // Registered channel state
  logic [NCH-1:0][CW-1:0] cnt_p0;
  logic [NCH-1:0][CW-1:0] lim_act_p0;
  logic [NCH-1:0][CW-1:0] lim_pend_p0;
  logic [NCH-1:0]         phase_p0;
  logic [NCH-1:0]         en_p0;
  logic [NCH-1:0]         clk_p0;
  logic [NCH-1:0]         tick_p0;

  // Next-state values
  logic [NCH-1:0][CW-1:0] cnt_nxt;
  logic [NCH-1:0][CW-1:0] lim_act_nxt;
  logic [NCH-1:0][CW-1:0] lim_pend_nxt;
  logic [NCH-1:0]         phase_nxt;
  logic [NCH-1:0]         en_nxt;
  logic [NCH-1:0]         clk_nxt;
  logic [NCH-1:0]         tick_nxt;

  // Decoded, priority-resolved commands per channel
  logic [NCH-1:0]         inc_hit;
  logic [NCH-1:0]         dec_hit;
  logic [NCH-1:0]         tog_hit;
  logic [NCH-1:0]         wrap;

  // Command decode: inc beats dec beats toggle; an out-of-range i_sel
  // matches no channel, so its commands fall away.
  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    tog_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      if (i_sel == SW'(i)) begin
        inc_hit[i] = i_inc;
        dec_hit[i] = ~i_inc & i_dec;
        tog_hit[i] = ~i_inc & ~i_dec & i_tog_en;
      end
    end
  end

  // Pending limit of the addressed channel; 0 when nothing is addressed.
  always_comb begin
    o_lim_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (i_sel == SW'(i)) o_lim_sel = lim_pend_p0[i];
    end
  end

  always_comb begin
    cnt_nxt      = cnt_p0;
    lim_act_nxt  = lim_act_p0;
    lim_pend_nxt = lim_pend_p0;
    phase_nxt    = phase_p0;
    en_nxt       = en_p0;
    clk_nxt      = clk_p0;
    tick_nxt     = '0;
    wrap         = '0;
    for (int i = 0; i < NCH; i++) begin
      wrap[i] = (cnt_p0[i] == lim_act_p0[i]);

      if (inc_hit[i])      lim_pend_nxt[i] = sat_inc(lim_pend_p0[i]);
      else if (dec_hit[i]) lim_pend_nxt[i] = sat_dec(lim_pend_p0[i]);

      en_nxt[i] = en_p0[i] ^ tog_hit[i];

      if (i_sync) begin
        // Resync adopts the pending limit including an update made this
        // cycle, and suppresses the tick of a coincident wrap.
        cnt_nxt[i]     = '0;
        phase_nxt[i]   = 1'b0;
        lim_act_nxt[i] = lim_pend_nxt[i];
        tick_nxt[i]    = 1'b0;
      end else if (wrap[i]) begin
        // The active limit only changes here, while cnt restarts at 0, so
        // cnt can never be left above lim_act.
        cnt_nxt[i]     = '0;
        phase_nxt[i]   = ~phase_p0[i];
        lim_act_nxt[i] = lim_pend_p0[i];
        tick_nxt[i]    = 1'b1;
      end else begin
        cnt_nxt[i]     = cnt_p0[i] + ONE_C;
      end

      // Gating is folded into the flop input so o_clk is glitch-free.
      clk_nxt[i] = phase_nxt[i] & en_nxt[i];
    end
  end

  // State / output register stage
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_p0      <= '0;
      lim_act_p0  <= {NCH{LIM_INIT_C}};
      lim_pend_p0 <= {NCH{LIM_INIT_C}};
      phase_p0    <= '0;
      en_p0       <= '0;
      clk_p0      <= '0;
      tick_p0     <= '0;
    end else begin
      cnt_p0      <= cnt_nxt;
      lim_act_p0  <= lim_act_nxt;
      lim_pend_p0 <= lim_pend_nxt;
      phase_p0    <= phase_nxt;
      en_p0       <= en_nxt;
      clk_p0      <= clk_nxt;
      tick_p0     <= tick_nxt;
    end
  end

  assign o_clk  = clk_p0;
  assign o_tick = tick_p0;
  assign o_en   = en_p0;

endmodule
